// File: rtl/ahb_protocol_checker.sv
// rtl/ahb_protocol_checker.sv - passive AHB protocol checker
// Observes one slave's bus and reports rule violations through sticky flags, counters and a first-error capture.
module ahb_protocol_checker #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_HSIZE    = 2,
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hsel,
  input  logic [1:0]            htrans,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic                  hready_in,
  input  logic                  hready_out,
  input  logic [1:0]            hresp,
  input  logic                  en,
  input  logic                  clr,
  output logic [6:0]            err_flags,
  output logic                  err_pulse,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic                  first_err_valid,
  output logic [2:0]            first_err_code,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam logic [1:0] HT_IDLE   = 2'd0;
  localparam logic [1:0] HT_BUSY   = 2'd1;
  localparam logic [1:0] HT_NONSEQ = 2'd2;
  localparam logic [1:0] HT_SEQ    = 2'd3;
  localparam logic [1:0] RESP_ERR  = 2'd1;
  localparam logic [0:0] B_IDLE    = 1'b0;
  localparam logic [0:0] B_ACTIVE  = 1'b1;
  localparam int         WW        = 11;
  localparam logic [WW-1:0]        WAIT_LIMIT = WW'(WAIT_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [2:0]           SIZE_MAX   = 3'(MAX_HSIZE);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64 && DATA_WIDTH != 128) begin : g_bad_data_width
    $error("DATA_WIDTH must be 32, 64 or 128");
  end
  if ((1 << MAX_HSIZE) > DATA_WIDTH / 8) begin : g_bad_max_hsize
    $error("MAX_HSIZE exceeds the bus data width");
  end
  if (WAIT_TIMEOUT < 1 || WAIT_TIMEOUT > 1023) begin : g_bad_timeout
    $error("WAIT_TIMEOUT must be in 1..1023");
  end

  logic [0:0]            burst_q, burst_d;
  logic [4:0]            beat_q, beat_d;
  logic [2:0]            btype_q, btype_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [2:0]            last_size_q, last_size_d;
  logic                  last_write_q, last_write_d;
  logic                  stall_q, stall_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic                  bus_write_q, bus_write_d;
  logic [2:0]            bus_size_q, bus_size_d;
  logic [1:0]            bus_trans_q, bus_trans_d;
  logic                  pend_q, pend_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic                  err_wait_q, err_wait_d;
  logic [6:0]            flags_q, flags_d;
  logic                  pulse_q, pulse_d;
  logic [CNT_WIDTH-1:0]  ecnt_q, ecnt_d, xcnt_q, xcnt_d;
  logic                  fv_q, fv_d;
  logic [2:0]            fcode_q, fcode_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;

  logic                  active_trans, acc, burst_fixed, any_viol;
  logic [4:0]            burst_len;
  logic [ADDR_WIDTH-1:0] align_mask, seq_addr;
  logic [6:0]            viol;
  logic [2:0]            low_code;

  // Rule evaluation on the current bus sample against the tracked state.
  always_comb begin
    active_trans = (htrans == HT_NONSEQ) || (htrans == HT_SEQ);
    acc          = hsel && hready_in && active_trans;
    align_mask   = ~({ADDR_WIDTH{1'b1}} << hsize);
    seq_addr     = last_addr_q + ({{(ADDR_WIDTH-1){1'b0}}, 1'b1} << hsize);
    viol    = '0;
    viol[0] = stall_q && ((haddr != bus_addr_q) || (hwrite != bus_write_q) ||
                          (hsize != bus_size_q) || (htrans != bus_trans_q));
    viol[1] = acc && (hsize > SIZE_MAX);
    viol[2] = acc && (|(haddr & align_mask));
    viol[3] = (burst_q == B_IDLE) && ((htrans == HT_SEQ) || (htrans == HT_BUSY));
    // Odd hburst encodings are the INCR family; WRAP beats skip only the address test.
    viol[4] = (burst_q == B_ACTIVE) && acc && (htrans == HT_SEQ) &&
              ((hsize != last_size_q) || (hwrite != last_write_q) ||
               (btype_q[0] && (haddr != seq_addr)));
    viol[5] = pend_q && !hready_out && (wait_q == WAIT_LIMIT);
    viol[6] = (hresp == RESP_ERR) && hready_out && !err_wait_q;
    any_viol = |viol;
    low_code = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (viol[i]) low_code = 3'(i);
    end
  end

  // Bus tracking, independent of en and clr.
  always_comb begin
    burst_fixed  = (btype_q[2:1] != 2'd0);
    case (btype_q[2:1])
      2'd1:    burst_len = 5'd4;
      2'd2:    burst_len = 5'd8;
      2'd3:    burst_len = 5'd16;
      default: burst_len = 5'd0;
    endcase
    burst_d      = burst_q;
    beat_d       = beat_q;
    btype_d      = btype_q;
    last_addr_d  = last_addr_q;
    last_size_d  = last_size_q;
    last_write_d = last_write_q;
    if (acc) begin
      last_addr_d  = haddr;
      last_size_d  = hsize;
      last_write_d = hwrite;
    end
    if (acc && (htrans == HT_NONSEQ)) begin
      burst_d = (hburst != 3'd0) ? B_ACTIVE : B_IDLE;
      beat_d  = 5'd1;
      btype_d = hburst;
    end else if (burst_q == B_ACTIVE) begin
      if (htrans == HT_IDLE) begin
        burst_d = B_IDLE;
      end else if (acc && (htrans == HT_SEQ)) begin
        beat_d = beat_q + 5'd1;
        if (burst_fixed && (beat_d == burst_len)) burst_d = B_IDLE;
      end
    end
    stall_d     = hsel && active_trans && !hready_in;
    bus_addr_d  = haddr;
    bus_write_d = hwrite;
    bus_size_d  = hsize;
    bus_trans_d = htrans;
    pend_d      = acc || (pend_q && !hready_out);
    // Counter parks one past the limit so a long wait reports only once.
    if (pend_q && !hready_out) begin
      wait_d = (wait_q > WAIT_LIMIT) ? wait_q : wait_q + WW'(1);
    end else begin
      wait_d = '0;
    end
    err_wait_d = (hresp == RESP_ERR) && !hready_out;
  end

  always_comb begin
    flags_d = flags_q;
    pulse_d = 1'b0;
    ecnt_d  = ecnt_q;
    xcnt_d  = xcnt_q;
    fv_d    = fv_q;
    fcode_d = fcode_q;
    faddr_d = faddr_q;
    if (clr) begin
      flags_d = '0;
      ecnt_d  = '0;
      xcnt_d  = '0;
      fv_d    = 1'b0;
      fcode_d = '0;
      faddr_d = '0;
    end else if (en) begin
      flags_d = flags_q | viol;
      pulse_d = any_viol;
      if (any_viol && (ecnt_q != CNT_MAX)) ecnt_d = ecnt_q + 1'b1;
      if (acc && (xcnt_q != CNT_MAX)) xcnt_d = xcnt_q + 1'b1;
      if (any_viol && !fv_q) begin
        fv_d    = 1'b1;
        fcode_d = low_code;
        faddr_d = haddr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_q <= B_IDLE;      beat_q <= '0;          btype_q <= '0;
      last_addr_q <= '0;      last_size_q <= '0;     last_write_q <= 1'b0;
      stall_q <= 1'b0;        bus_addr_q <= '0;      bus_write_q <= 1'b0;
      bus_size_q <= '0;       bus_trans_q <= '0;     pend_q <= 1'b0;
      wait_q <= '0;           err_wait_q <= 1'b0;    flags_q <= '0;
      pulse_q <= 1'b0;        ecnt_q <= '0;          xcnt_q <= '0;
      fv_q <= 1'b0;           fcode_q <= '0;         faddr_q <= '0;
    end else begin
      burst_q <= burst_d;     beat_q <= beat_d;      btype_q <= btype_d;
      last_addr_q <= last_addr_d;  last_size_q <= last_size_d;  last_write_q <= last_write_d;
      stall_q <= stall_d;     bus_addr_q <= bus_addr_d;  bus_write_q <= bus_write_d;
      bus_size_q <= bus_size_d;    bus_trans_q <= bus_trans_d;  pend_q <= pend_d;
      wait_q <= wait_d;       err_wait_q <= err_wait_d;  flags_q <= flags_d;
      pulse_q <= pulse_d;     ecnt_q <= ecnt_d;      xcnt_q <= xcnt_d;
      fv_q <= fv_d;           fcode_q <= fcode_d;    faddr_q <= faddr_d;
    end
  end

  assign err_flags       = flags_q;
  assign err_pulse       = pulse_q;
  assign err_count       = ecnt_q;
  assign xfer_count      = xcnt_q;
  assign first_err_valid = fv_q;
  assign first_err_code  = fcode_q;
  assign first_err_addr  = faddr_q;

endmodule

// File: tb/tb_ahb_protocol_checker.sv
// tb/tb_ahb_protocol_checker.sv - scoreboard bench for ahb_protocol_checker
module tb_ahb_protocol_checker;

  localparam logic [1:0] IDLE = 2'd0, NS = 2'd2, SEQ = 2'd3, ERR = 2'd1;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3;

  logic        clk = 1'b0;
  logic        rst, en, clr;
  logic        hsel, hwrite, hready_in, hready_out;
  logic [1:0]  htrans, hresp;
  logic [31:0] haddr;
  logic [2:0]  hsize, hburst;
  logic [6:0]  err_flags;
  logic        err_pulse, first_err_valid;
  logic [3:0]  err_count, xfer_count;
  logic [2:0]  first_err_code;
  logic [31:0] first_err_addr;

  always #5 clk = ~clk;

  ahb_protocol_checker #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_HSIZE(2), .WAIT_TIMEOUT(16), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .htrans(htrans), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hready_in(hready_in), .hready_out(hready_out),
    .hresp(hresp), .en(en), .clr(clr), .err_flags(err_flags), .err_pulse(err_pulse),
    .err_count(err_count), .xfer_count(xfer_count), .first_err_valid(first_err_valid),
    .first_err_code(first_err_code), .first_err_addr(first_err_addr)
  );

  typedef struct {
    logic [95:0] tag;
    int          due;
    logic [6:0]  flags;
    logic        pulse;
    logic [3:0]  ecnt;
    logic [3:0]  xcnt;
    logic        fv;
    logic [2:0]  fcode;
    logic [31:0] faddr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc_n) begin
      mon_e = sb_q.pop_front();
      check($sformatf("%0s.flags", mon_e.tag), 32'(err_flags),       32'(mon_e.flags));
      check($sformatf("%0s.pulse", mon_e.tag), 32'(err_pulse),       32'(mon_e.pulse));
      check($sformatf("%0s.ecnt", mon_e.tag),  32'(err_count),       32'(mon_e.ecnt));
      check($sformatf("%0s.xcnt", mon_e.tag),  32'(xfer_count),      32'(mon_e.xcnt));
      check($sformatf("%0s.fv", mon_e.tag),    32'(first_err_valid), 32'(mon_e.fv));
      check($sformatf("%0s.fcode", mon_e.tag), 32'(first_err_code),  32'(mon_e.fcode));
      check($sformatf("%0s.faddr", mon_e.tag), first_err_addr,       mon_e.faddr);
    end
  end

  task automatic bus(input logic s, input logic [1:0] t, input logic [31:0] a, input logic w,
                     input logic [2:0] sz, input logic [2:0] b, input logic rin,
                     input logic rout, input logic [1:0] r);
    hsel = s; htrans = t; haddr = a; hwrite = w; hsize = sz; hburst = b;
    hready_in = rin; hready_out = rout; hresp = r;
  endtask

  task automatic idle();
    bus(1'b0, IDLE, 32'h0, 1'b0, 3'd0, SINGLE, 1'b1, 1'b1, 2'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs visible after the next rising edge.
  task automatic exp_push(input logic [95:0] tag, input logic [6:0] f, input logic p,
                          input logic [3:0] ec, input logic [3:0] xc, input logic fv,
                          input logic [2:0] fc, input logic [31:0] fa);
    exp_t e;
    e.tag = tag; e.due = cyc_n + 1; e.flags = f; e.pulse = p; e.ecnt = ec;
    e.xcnt = xc; e.fv = fv; e.fcode = fc; e.faddr = fa;
    sb_q.push_back(e);
  endtask

  task automatic do_clr();
    clr = 1'b1; idle();
    exp_push("clr", 7'h0, 0, 0, 0, 0, 0, 0);
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b1; idle();
    tick();
    exp_push("reset", 7'h0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;

    // INCR burst, correct addresses
    bus(1, NS, 32'h100, 0, 2, INCR, 1, 1, 0);  exp_push("incr_b1", 0, 0, 0, 1, 0, 0, 0); tick();
    bus(1, SEQ, 32'h104, 0, 2, INCR, 1, 1, 0); exp_push("incr_b2", 0, 0, 0, 2, 0, 0, 0); tick();
    bus(1, SEQ, 32'h108, 0, 2, INCR, 1, 1, 0); exp_push("incr_b3", 0, 0, 0, 3, 0, 0, 0); tick();
    idle(); exp_push("incr_end", 0, 0, 0, 3, 0, 0, 0); tick();

    // WRAP4 wraps freely, then ends after beat 4
    do_clr();
    bus(1, NS, 32'h108, 0, 2, WRAP4, 1, 1, 0);  tick();
    bus(1, SEQ, 32'h10C, 0, 2, WRAP4, 1, 1, 0); tick();
    bus(1, SEQ, 32'h100, 0, 2, WRAP4, 1, 1, 0); tick();
    bus(1, SEQ, 32'h104, 0, 2, WRAP4, 1, 1, 0); exp_push("wrap_b4", 0, 0, 0, 4, 0, 0, 0); tick();
    bus(1, SEQ, 32'h108, 0, 2, WRAP4, 1, 1, 0); exp_push("wrap_over", 7'h08, 1, 1, 5, 1, 3, 32'h108); tick();
    idle(); exp_push("wrap_idle", 7'h08, 0, 1, 5, 1, 3, 32'h108); tick();

    // INCR address skip and hwrite change
    do_clr();
    bus(1, NS, 32'h700, 0, 2, INCR, 1, 1, 0);  exp_push("seq_ns", 0, 0, 0, 1, 0, 0, 0); tick();
    bus(1, SEQ, 32'h708, 0, 2, INCR, 1, 1, 0); exp_push("seq_skip", 7'h10, 1, 1, 2, 1, 4, 32'h708); tick();
    bus(1, SEQ, 32'h70C, 0, 2, INCR, 1, 1, 0); exp_push("seq_ok", 7'h10, 0, 1, 3, 1, 4, 32'h708); tick();
    bus(1, SEQ, 32'h710, 1, 2, INCR, 1, 1, 0); exp_push("seq_wr", 7'h10, 1, 2, 4, 1, 4, 32'h708); tick();
    idle(); exp_push("seq_idle", 7'h10, 0, 2, 4, 1, 4, 32'h708); tick();

    // address changes during a stall
    do_clr();
    bus(1, NS, 32'h200, 0, 2, SINGLE, 0, 0, 0); exp_push("stall_a", 0, 0, 0, 0, 0, 0, 0); tick();
    bus(1, NS, 32'h204, 0, 2, SINGLE, 1, 1, 0); exp_push("stall_chg", 7'h01, 1, 1, 1, 1, 0, 32'h204); tick();
    idle(); exp_push("stall_idle", 7'h01, 0, 1, 1, 1, 0, 32'h204); tick();
    do_clr();
    bus(1, NS, 32'h200, 0, 2, SINGLE, 0, 0, 0); tick();
    bus(1, NS, 32'h200, 0, 2, SINGLE, 1, 1, 0); exp_push("stall_hold", 0, 0, 0, 1, 0, 0, 0); tick();
    idle(); tick();

    // oversize and misaligned in one cycle, then a second violation
    do_clr();
    bus(1, NS, 32'h102, 0, 3, SINGLE, 1, 1, 0);  exp_push("size_align", 7'h06, 1, 1, 1, 1, 1, 32'h102); tick();
    bus(1, SEQ, 32'h300, 0, 2, SINGLE, 1, 1, 0); exp_push("seq_idle_fsm", 7'h0E, 1, 2, 2, 1, 1, 32'h102); tick();
    idle(); exp_push("size_idle", 7'h0E, 0, 2, 2, 1, 1, 32'h102); tick();

    // wait timeout fires on the 17th wait cycle only
    do_clr();
    bus(1, NS, 32'h400, 0, 2, SINGLE, 1, 1, 0); exp_push("to_ns", 0, 0, 0, 1, 0, 0, 0); tick();
    for (int k = 1; k <= 18; k++) begin
      bus(0, IDLE, 32'h0, 0, 2, SINGLE, 0, 0, 0);
      if (k == 16) exp_push("to_w16", 0, 0, 0, 1, 0, 0, 0);
      if (k == 17) exp_push("to_w17", 7'h20, 1, 1, 1, 1, 5, 32'h0);
      if (k == 18) exp_push("to_w18", 7'h20, 0, 1, 1, 1, 5, 32'h0);
      tick();
    end
    idle(); exp_push("to_done", 7'h20, 0, 1, 1, 1, 5, 32'h0); tick();

    // ERROR response: one-cycle is bad, two-cycle is fine
    do_clr();
    bus(0, IDLE, 32'h0, 0, 0, SINGLE, 1, 1, ERR); exp_push("resp_1cyc", 7'h40, 1, 1, 0, 1, 6, 32'h0); tick();
    bus(0, IDLE, 32'h0, 0, 0, SINGLE, 1, 0, ERR); exp_push("resp_w", 7'h40, 0, 1, 0, 1, 6, 32'h0); tick();
    bus(0, IDLE, 32'h0, 0, 0, SINGLE, 1, 1, ERR); exp_push("resp_2nd", 7'h40, 0, 1, 0, 1, 6, 32'h0); tick();
    do_clr();
    bus(0, IDLE, 32'h0, 0, 0, SINGLE, 1, 0, ERR); exp_push("resp2_a", 0, 0, 0, 0, 0, 0, 0); tick();
    bus(0, IDLE, 32'h0, 0, 0, SINGLE, 1, 1, ERR); exp_push("resp2_b", 0, 0, 0, 0, 0, 0, 0); tick();
    idle(); exp_push("resp2_idle", 0, 0, 0, 0, 0, 0, 0); tick();

    // counter saturation, en gating, clr beating a violation
    do_clr();
    for (int k = 1; k <= 20; k++) begin
      bus(1, NS, 32'h500, 0, 2, SINGLE, 1, 1, ERR);
      exp_push("sat", 7'h40, 1, (k > 15) ? 4'd15 : 4'(k), (k > 15) ? 4'd15 : 4'(k), 1, 6, 32'h500);
      tick();
    end
    en = 1'b0;
    bus(1, NS, 32'h500, 0, 2, SINGLE, 1, 1, ERR); exp_push("en_off", 7'h40, 0, 15, 15, 1, 6, 32'h500); tick();
    en = 1'b1; clr = 1'b1;
    bus(1, NS, 32'h500, 0, 2, SINGLE, 1, 1, ERR); exp_push("clr_wins", 0, 0, 0, 0, 0, 0, 0); tick();
    clr = 1'b0;
    idle(); exp_push("clr_after", 0, 0, 0, 0, 0, 0, 0); tick();
    en = 1'b0;
    bus(0, IDLE, 32'h0, 0, 0, SINGLE, 1, 1, ERR); exp_push("en_off_clean", 0, 0, 0, 0, 0, 0, 0); tick();
    en = 1'b1;
    idle(); exp_push("en_back", 0, 0, 0, 0, 0, 0, 0); tick();

    // reset mid-burst abandons the burst
    bus(1, NS, 32'h600, 0, 2, INCR4, 1, 1, 0); exp_push("rb_ns", 0, 0, 0, 1, 0, 0, 0); tick();
    rst = 1'b1;
    bus(1, SEQ, 32'h604, 0, 2, INCR4, 1, 1, 0); exp_push("rb_rst", 0, 0, 0, 0, 0, 0, 0); tick();
    rst = 1'b0;
    bus(1, SEQ, 32'h608, 0, 2, INCR4, 1, 1, 0); exp_push("rb_seq", 7'h08, 1, 1, 1, 1, 3, 32'h608); tick();
    idle(); exp_push("rb_idle", 7'h08, 0, 1, 1, 1, 3, 32'h608); tick();

    tick();
    tick();
    @(negedge clk);
    #1;
    check("drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
